// File: rtl/spi_multi_master.sv
// SPI master with one shared shift engine fanned out to NUM_SLAVES chip-select domains.
// Each command selects slave, bit count, CPOL/CPHA and divider; unselected slaves stay gated low.
module spi_multi_master #(
   parameter int unsigned           NUM_SLAVES = 9,
   parameter int unsigned           SLW        = 4,
   parameter int unsigned           MAX_BITS   = 32,
   parameter int unsigned           DIVW       = 16,
   parameter logic [NUM_SLAVES-1:0] MISO_MASK  = '1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [SLW-1:0]        cmd_slave,
   input  logic [MAX_BITS-1:0]   cmd_data,
   input  logic [5:0]            cmd_nbits,
   input  logic                  cmd_cpol,
   input  logic                  cmd_cpha,
   input  logic [DIVW-1:0]       cmd_div,
   output logic                  resp_valid,
   output logic [MAX_BITS-1:0]   resp_data,
   output logic                  resp_err,
   output logic                  busy,
   output logic [NUM_SLAVES-1:0] sen,
   output logic [NUM_SLAVES-1:0] sclk,
   output logic [NUM_SLAVES-1:0] mosi,
   input  logic [NUM_SLAVES-1:0] miso
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SETUP = 3'd1;
   localparam logic [2:0] SHIFT = 3'd2;
   localparam logic [2:0] HOLD  = 3'd3;
   localparam logic [2:0] GAP   = 3'd4;
   localparam logic [2:0] ERR   = 3'd5;

   logic [2:0]            state_q, state_d;
   logic [SLW-1:0]        slv_q, slv_d;
   logic [5:0]            nbits_q, nbits_d;
   logic                  cpha_q, cpha_d;
   logic [DIVW-1:0]       div_q, div_d;
   logic [DIVW-1:0]       cnt_q, cnt_d;
   logic [6:0]            edge_q, edge_d;
   logic                  lvl_q, lvl_d;
   logic [MAX_BITS-1:0]   tx_q, tx_d;
   logic [MAX_BITS-1:0]   rx_q, rx_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_err_q, resp_err_d;
   logic [MAX_BITS-1:0]   resp_data_q, resp_data_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  busy_q, busy_d;
   logic [NUM_SLAVES-1:0] sen_q, sen_d;
   logic [NUM_SLAVES-1:0] sclk_q, sclk_d;
   logic [NUM_SLAVES-1:0] mosi_q, mosi_d;

   logic       cmd_bad;
   logic       wrap;
   logic       do_edge;
   logic       leading;
   logic [6:0] edge_num;
   logic       miso_bit;

   assign cmd_bad = (32'(cmd_slave) >= NUM_SLAVES) || (cmd_nbits == 6'd0) ||
                    (32'(cmd_nbits) > MAX_BITS);
   assign wrap     = (cnt_q == div_q);
   assign edge_num = (state_q == SETUP) ? 7'd1 : edge_q + 7'd1;
   // Odd-numbered SCLK transitions are leading edges.
   assign leading  = edge_num[0];

   always_comb begin
      miso_bit = 1'b0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (slv_q == SLW'(i)) miso_bit = miso[i] & MISO_MASK[i];
      end
   end

   always_comb begin
      state_d      = state_q;
      slv_d        = slv_q;
      nbits_d      = nbits_q;
      cpha_d       = cpha_q;
      div_d        = div_q;
      cnt_d        = cnt_q;
      edge_d       = edge_q;
      lvl_d        = lvl_q;
      tx_d         = tx_q;
      rx_d         = rx_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      resp_data_d  = resp_data_q;
      do_edge      = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_bad) begin
                  state_d = ERR;
               end else begin
                  state_d = SETUP;
                  slv_d   = cmd_slave;
                  nbits_d = cmd_nbits;
                  cpha_d  = cmd_cpha;
                  div_d   = cmd_div;
                  cnt_d   = '0;
                  edge_d  = '0;
                  lvl_d   = cmd_cpol;
                  // Left-align so the current bit is always the MSB.
                  tx_d    = cmd_data << (MAX_BITS - 32'(cmd_nbits));
                  rx_d    = '0;
               end
            end
         end
         ERR: begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
         end
         SETUP, SHIFT, HOLD, GAP: begin
            if (!wrap) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               if (state_q == SETUP) begin
                  state_d = SHIFT;
                  edge_d  = 7'd1;
                  lvl_d   = ~lvl_q;
                  do_edge = 1'b1;
               end else if (state_q == SHIFT) begin
                  if (edge_q == {nbits_q, 1'b0}) begin
                     state_d = HOLD;
                  end else begin
                     edge_d  = edge_q + 7'd1;
                     lvl_d   = ~lvl_q;
                     do_edge = 1'b1;
                  end
               end else if (state_q == HOLD) begin
                  state_d = GAP;
               end else begin
                  state_d      = IDLE;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b0;
                  resp_data_d  = rx_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (do_edge && (cpha_q ? !leading : leading)) begin
         rx_d = (rx_q << 1) | MAX_BITS'(miso_bit);
      end
      // With CPHA=1 the MSB is already on the line, so the first leading edge does not shift.
      if (do_edge && (cpha_q ? (leading && edge_num != 7'd1) : !leading)) begin
         tx_d = tx_q << 1;
      end
   end

   always_comb begin
      cmd_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      sen_d       = '1;
      sclk_d      = '0;
      mosi_d      = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (slv_d == SLW'(i)) begin
            if (state_d == SETUP || state_d == SHIFT || state_d == HOLD) begin
               sen_d[i]  = 1'b0;
               mosi_d[i] = tx_d[MAX_BITS-1];
            end
            if (state_d == SETUP || state_d == SHIFT || state_d == HOLD || state_d == GAP) begin
               sclk_d[i] = lvl_d;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         slv_q        <= '0;
         nbits_q      <= '0;
         cpha_q       <= 1'b0;
         div_q        <= '0;
         cnt_q        <= '0;
         edge_q       <= '0;
         lvl_q        <= 1'b0;
         tx_q         <= '0;
         rx_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= '0;
         cmd_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         sen_q        <= '1;
         sclk_q       <= '0;
         mosi_q       <= '0;
      end else begin
         state_q      <= state_d;
         slv_q        <= slv_d;
         nbits_q      <= nbits_d;
         cpha_q       <= cpha_d;
         div_q        <= div_d;
         cnt_q        <= cnt_d;
         edge_q       <= edge_d;
         lvl_q        <= lvl_d;
         tx_q         <= tx_d;
         rx_q         <= rx_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_data_q  <= resp_data_d;
         cmd_ready_q  <= cmd_ready_d;
         busy_q       <= busy_d;
         sen_q        <= sen_d;
         sclk_q       <= sclk_d;
         mosi_q       <= mosi_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign busy       = busy_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_data  = resp_data_q;
   assign sen        = sen_q;
   assign sclk       = sclk_q;
   assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_multi_master.sv
// Directed bench for spi_multi_master: modes, slave gating, rejection, back-to-back and reset.
module tb_spi_multi_master;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_slave;
   logic [31:0] cmd_data;
   logic [5:0]  cmd_nbits;
   logic        cmd_cpol;
   logic        cmd_cpha;
   logic [15:0] cmd_div;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        busy;
   logic [8:0]  sen;
   logic [8:0]  sclk;
   logic [8:0]  mosi;
   logic [8:0]  miso;

   logic        m8;
   logic        m2;
   logic [23:0] slv_word;
   int          slv_idx;

   int checks;
   int errors;
   int cyc;

   logic sen_h  [0:1023];
   logic sclk_h [0:1023];

   spi_multi_master #(
      .NUM_SLAVES(9),
      .SLW(4),
      .MAX_BITS(32),
      .DIVW(16),
      .MISO_MASK(9'h1FB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_slave(cmd_slave),
      .cmd_data(cmd_data),
      .cmd_nbits(cmd_nbits),
      .cmd_cpol(cmd_cpol),
      .cmd_cpha(cmd_cpha),
      .cmd_div(cmd_div),
      .resp_valid(resp_valid),
      .resp_data(resp_data),
      .resp_err(resp_err),
      .busy(busy),
      .sen(sen),
      .sclk(sclk),
      .mosi(mosi),
      .miso(miso)
   );

   // Slave 3 loops MOSI back, slave 2 drives a constant, slave 8 is a CPOL=1/CPHA=1 shifter.
   assign miso = {m8, 4'b0000, mosi[3], m2, 2'b00};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge sen[8]) begin
      slv_idx = 23;
   end

   always @(negedge sclk[8]) begin
      if (!sen[8] && slv_idx >= 0) begin
         m8      = slv_word[slv_idx];
         slv_idx = slv_idx - 1;
      end
   end

   task automatic do_cmd(input logic [3:0] sl, input logic [31:0] d, input logic [5:0] nb,
                         input logic pol, input logic pha, input logic [15:0] dv,
                         output int lat, output int sen_low, output int rises,
                         output logic [31:0] rd, output logic re, output logic other_act,
                         output logic sen_any, output logic multi_sen);
      int   t0;
      logic prev;
      logic [8:0] oh;
      lat = -1; sen_low = 0; rises = 0; rd = 'x; re = 'x;
      other_act = 1'b0; sen_any = 1'b0; multi_sen = 1'b0;
      oh = 9'd1 << sl;
      @(negedge clk);
      for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
      cmd_slave = sl; cmd_data = d; cmd_nbits = nb;
      cmd_cpol = pol; cmd_cpha = pha; cmd_div = dv;
      cmd_valid = 1'b1;
      t0 = cyc;
      prev = 1'b0;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (sl < 4'd9) begin
            sen_h[cyc - t0]  = sen[sl];
            sclk_h[cyc - t0] = sclk[sl];
            if (!sen[sl]) sen_low++;
            if (sclk[sl] && !prev) rises++;
            prev = sclk[sl];
         end
         if (((sclk | mosi) & ~oh) != 9'd0) other_act = 1'b1;
         if (sen != 9'h1FF) sen_any = 1'b1;
         if ($countones(~sen) > 1) multi_sen = 1'b1;
         if (resp_valid) begin
            lat = cyc - t0;
            rd  = resp_data;
            re  = resp_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (sen !== 9'h1FF || sclk !== 9'h0 || mosi !== 9'h0) begin
         errors++;
         $display("FAIL reset_lines: sen=%h sclk=%h mosi=%h required 1ff/000/000", sen, sclk, mosi);
      end
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: ready=%b busy=%b required 1/0", cmd_ready, busy);
      end
      checks++;
      if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_resp: valid=%b err=%b data=%h required 0/0/0",
                  resp_valid, resp_err, resp_data);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mode0();
      int lat, low, rises;
      logic [31:0] rd;
      logic re, oth, any, multi;
      do_cmd(4'd3, 32'hA5, 6'd8, 1'b0, 1'b0, 16'd0, lat, low, rises, rd, re, oth, any, multi);
      checks++;
      if (low !== 18) begin
         errors++; $display("FAIL mode0_sen_low: got %0d required 18", low);
      end
      checks++;
      if (rises !== 8) begin
         errors++; $display("FAIL mode0_rises: got %0d required 8", rises);
      end
      checks++;
      if (sen_h[1] !== 1'b0) begin
         errors++; $display("FAIL mode0_sen_fall: sen[3]@t0+1=%b required 0", sen_h[1]);
      end
      checks++;
      if (lat !== 20) begin
         errors++; $display("FAIL mode0_latency: got %0d required 20", lat);
      end
      checks++;
      if (rd !== 32'hA5 || re !== 1'b0) begin
         errors++; $display("FAIL mode0_data: data=%h err=%b required a5/0", rd, re);
      end
      checks++;
      if (oth !== 1'b0 || multi !== 1'b0) begin
         errors++; $display("FAIL mode0_gating: other=%b multi=%b required 0/0", oth, multi);
      end
   endtask

   task automatic test_reject();
      int lat, low, rises;
      logic [31:0] rd;
      logic re, oth, any, multi;
      logic [3:0]  sls [3] = '{4'd12, 4'd1, 4'd1};
      logic [5:0]  nbs [3] = '{6'd8, 6'd0, 6'd40};
      for (int i = 0; i < 3; i++) begin
         do_cmd(sls[i], 32'hFFFF_FFFF, nbs[i], 1'b0, 1'b0, 16'd0,
                lat, low, rises, rd, re, oth, any, multi);
         checks++;
         if (lat !== 2 || re !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL reject_%0d: lat=%0d err=%b data=%h required 2/1/0", i, lat, re, rd);
         end
         checks++;
         if (any !== 1'b0 || oth !== 1'b0) begin
            errors++;
            $display("FAIL reject_quiet_%0d: sen_active=%b edges=%b required 0/0", i, any, oth);
         end
      end
   endtask

   task automatic test_cpol1_cpha1();
      int lat, low, rises;
      logic [31:0] rd;
      logic re, oth, any, multi;
      slv_word = 24'h123456;
      do_cmd(4'd8, 32'hC3C3C3, 6'd24, 1'b1, 1'b1, 16'd3, lat, low, rises, rd, re, oth, any, multi);
      checks++;
      if (sclk_h[1] !== 1'b1 || sclk_h[4] !== 1'b1) begin
         errors++; $display("FAIL m3_setup_idle: %b%b required 11", sclk_h[1], sclk_h[4]);
      end
      checks++;
      if (sclk_h[5] !== 1'b0 || sclk_h[9] !== 1'b1 || sclk_h[12] !== 1'b1 || sclk_h[13] !== 1'b0)
      begin
         errors++;
         $display("FAIL m3_period: @5,9,12,13=%b%b%b%b required 0110",
                  sclk_h[5], sclk_h[9], sclk_h[12], sclk_h[13]);
      end
      checks++;
      if (sclk_h[197] !== 1'b1 || sclk_h[200] !== 1'b1 || sen_h[200] !== 1'b0 ||
          sen_h[201] !== 1'b1) begin
         errors++;
         $display("FAIL m3_hold: sclk=%b%b sen@200=%b sen@201=%b required 11/0/1",
                  sclk_h[197], sclk_h[200], sen_h[200], sen_h[201]);
      end
      checks++;
      if (lat !== 205) begin
         errors++; $display("FAIL m3_latency: got %0d required 205", lat);
      end
      checks++;
      if (rd !== 32'h123456 || re !== 1'b0) begin
         errors++; $display("FAIL m3_data: data=%h err=%b required 123456/0", rd, re);
      end
      checks++;
      if (oth !== 1'b0 || multi !== 1'b0) begin
         errors++; $display("FAIL m3_others: other=%b multi=%b required 0/0", oth, multi);
      end
   endtask

   task automatic test_no_miso();
      int lat, low, rises;
      logic [31:0] rd;
      logic re, oth, any, multi;
      m2 = 1'b1;
      do_cmd(4'd2, 32'hFFFF, 6'd16, 1'b0, 1'b0, 16'd0, lat, low, rises, rd, re, oth, any, multi);
      m2 = 1'b0;
      checks++;
      if (rd !== 32'h0 || re !== 1'b0 || lat !== 36) begin
         errors++; $display("FAIL no_miso: data=%h err=%b lat=%0d required 0/0/36", rd, re, lat);
      end
   endtask

   task automatic test_back_to_back();
      int   t0, nresp, r1, r2, ph, gap;
      logic ready1;
      nresp = 0; r1 = -1; r2 = -1; ph = 0; gap = 0; ready1 = 1'b0;
      @(negedge clk);
      cmd_slave = 4'd0; cmd_data = 32'hDEADBEEF; cmd_nbits = 6'd32;
      cmd_cpol = 1'b0; cmd_cpha = 1'b0; cmd_div = 16'd1;
      cmd_valid = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #1 cmd_data = 32'h00000001;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         case (ph)
            0: if (!sen[0]) ph = 1;
            1: if (sen[0]) begin ph = 2; gap = 1; end
            2: if (sen[0]) gap++; else ph = 3;
            default: ;
         endcase
         if (resp_valid) begin
            nresp++;
            if (nresp == 1) begin
               r1 = cyc - t0;
               ready1 = cmd_ready;
               @(posedge clk);
               #1 cmd_valid = 1'b0;
            end else begin
               r2 = cyc - t0;
               break;
            end
         end
      end
      cmd_valid = 1'b0;
      checks++;
      if (r1 !== 135 || ready1 !== 1'b1) begin
         errors++; $display("FAIL b2b_first: lat=%0d ready=%b required 135/1", r1, ready1);
      end
      checks++;
      if (r2 !== 270) begin
         errors++; $display("FAIL b2b_second: lat=%0d required 270", r2);
      end
      checks++;
      if (ph != 3 || gap < 2) begin
         errors++; $display("FAIL b2b_gap: high cycles=%0d phase=%0d required >=2/3", gap, ph);
      end
   endtask

   task automatic test_reset_mid();
      int lat, low, rises, pulses;
      logic [31:0] rd;
      logic re, oth, any, multi;
      @(negedge clk);
      cmd_slave = 4'd3; cmd_data = 32'h5A; cmd_nbits = 6'd8;
      cmd_cpol = 1'b0; cmd_cpha = 1'b0; cmd_div = 16'd2;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (sen[3] !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL rst_pre: sen3=%b busy=%b required 0/1", sen[3], busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (sen !== 9'h1FF || sclk !== 9'h0 || mosi !== 9'h0) begin
         errors++;
         $display("FAIL rst_async: sen=%h sclk=%h mosi=%h required 1ff/000/000", sen, sclk, mosi);
      end
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (resp_valid) pulses++;
      end
      checks++;
      if (pulses !== 0 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL rst_after: resp pulses=%0d ready=%b required 0/1", pulses, cmd_ready);
      end
      do_cmd(4'd3, 32'h3C, 6'd8, 1'b0, 1'b0, 16'd0, lat, low, rises, rd, re, oth, any, multi);
      checks++;
      if (lat !== 20 || rd !== 32'h3C || re !== 1'b0) begin
         errors++; $display("FAIL rst_recover: lat=%0d data=%h err=%b required 20/3c/0", lat, rd, re);
      end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      m8 = 1'b0; m2 = 1'b0; slv_word = 24'h0; slv_idx = -1;
      cmd_valid = 1'b0; cmd_slave = '0; cmd_data = '0; cmd_nbits = '0;
      cmd_cpol = 1'b0; cmd_cpha = 1'b0; cmd_div = '0;
      test_reset();
      test_mode0();
      test_reject();
      test_cpol1_cpha1();
      test_no_miso();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
